// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : button_pkg
//  Purpose  : Shared definitions for the multi-channel button conditioner:
//             hold/repeat FSM encoding and the counter-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package button_pkg;

   // Hold/repeat sequencing state of one channel
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } hold_state_t;

   // Largest of three timing values; sizes the shared counter width
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage : button_pkg
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
//  Module   : button_channel
//  Purpose  : One button channel: 2-FF synchroniser with polarity fix,
//             counter debounce, press/release edge pulses and the
//             hold / auto-repeat sequencer. Every output is a flop.
//  Revision : 1.0  initial release
// ============================================================================
module button_channel
   import button_pkg::*;
#(
   parameter bit          ACTIVE_LOW      = 1'b0,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned HOLD_CYCLES     = 0,
   parameter int unsigned REPEAT_CYCLES   = 0,
   parameter int unsigned CNT_W           = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_button,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_press,
   output logic event_pulse
);

   localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_hold     = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] c_rep      = CNT_W'(REPEAT_CYCLES);
   localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

   logic             r_s0;
   logic             r_s1;
   logic             r_stable;
   logic [CNT_W-1:0] r_db_cnt;

   hold_state_t      r_state;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] r_rep_cnt;
   logic             r_parked;

   logic             r_level;
   logic             r_press;
   logic             r_release;
   logic             r_long;
   logic             r_event;

   logic             w_rise;
   logic             w_fall;

   // Two-flop synchroniser; inversion applied at the first flop so that
   // everything downstream treats 1 as pressed
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s0 <= 1'b0;
         r_s1 <= 1'b0;
      end else begin
         r_s0 <= raw_button ^ ACTIVE_LOW;
         r_s1 <= r_s0;
      end
   end

   // Debounce: stable state flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stable <= 1'b0;
         r_db_cnt <= '0;
      end else if (r_s1 != r_stable) begin
         if (r_db_cnt == c_deb_last) begin
            r_stable <= r_s1;
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + c_one;
         end
      end else begin
         r_db_cnt <= '0;
      end
   end

   // Edge of the debounced state against the registered level output
   assign w_rise = r_stable & ~r_level;
   assign w_fall = ~r_stable & r_level;

   // Level/edge outputs plus hold and auto-repeat sequencer; a release always
   // returns to idle and suppresses any tick due on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         r_level    <= 1'b0;
         r_press    <= 1'b0;
         r_release  <= 1'b0;
         r_long     <= 1'b0;
         r_event    <= 1'b0;
         r_state    <= ST_IDLE;
         r_hold_cnt <= '0;
         r_rep_cnt  <= '0;
         r_parked   <= 1'b0;
      end else begin
         r_level   <= r_stable;
         r_press   <= w_rise;
         r_release <= w_fall;
         r_long    <= 1'b0;
         r_event   <= w_rise;

         if (w_fall) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_parked   <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  // With no hold time the channel simply stays idle while pressed
                  if (w_rise && (HOLD_CYCLES != 0)) begin
                     r_state    <= ST_HOLD;
                     r_hold_cnt <= c_one;
                     r_parked   <= 1'b0;
                  end
               end
               ST_HOLD: begin
                  // Parked means the single long-press has fired and repeat is off
                  if (!r_parked) begin
                     if (r_hold_cnt == c_hold) begin
                        r_long  <= 1'b1;
                        r_event <= 1'b1;
                        if (REPEAT_CYCLES != 0) begin
                           r_state    <= ST_REPEAT;
                           r_hold_cnt <= '0;
                           r_rep_cnt  <= c_one;
                        end else begin
                           r_parked <= 1'b1;
                        end
                     end else begin
                        r_hold_cnt <= r_hold_cnt + c_one;
                     end
                  end
               end
               ST_REPEAT: begin
                  if (r_rep_cnt == c_rep) begin
                     r_event   <= 1'b1;
                     r_rep_cnt <= c_one;
                  end else begin
                     r_rep_cnt <= r_rep_cnt + c_one;
                  end
               end
               default: begin
                  r_state    <= ST_IDLE;
                  r_hold_cnt <= '0;
                  r_rep_cnt  <= '0;
                  r_parked   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign level         = r_level;
   assign press_pulse   = r_press;
   assign release_pulse = r_release;
   assign long_press    = r_long;
   assign event_pulse   = r_event;

endmodule : button_channel
`default_nettype wire

// File: rtl/multi_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : multi_button_conditioner
//  Purpose  : N independent front-panel button channels, each synchronised,
//             polarity-corrected, debounced and sequenced for long-press and
//             auto-repeat key events.
//  Revision : 1.0  initial release
// ============================================================================
module multi_button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned              NUM_CHANNELS    = 4,
   parameter logic [NUM_CHANNELS-1:0]  ACTIVE_LOW      = '0,
   parameter int unsigned              DEBOUNCE_CYCLES = 50000,
   parameter int unsigned              HOLD_CYCLES     = 0,
   parameter int unsigned              REPEAT_CYCLES   = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CHANNELS-1:0] raw_buttons,
   output logic [NUM_CHANNELS-1:0] level,
   output logic [NUM_CHANNELS-1:0] press_pulse,
   output logic [NUM_CHANNELS-1:0] release_pulse,
   output logic [NUM_CHANNELS-1:0] long_press,
   output logic [NUM_CHANNELS-1:0] event_pulse
);

   // One counter width covers debounce, hold and repeat timing
   localparam int unsigned CNT_W =
      $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) + 1);

   // One fully independent channel per button
   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
      button_channel #(
         .ACTIVE_LOW      (ACTIVE_LOW[i]),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES),
         .CNT_W           (CNT_W)
      ) u_channel (
         .clk           (clk),
         .reset         (reset),
         .raw_button    (raw_buttons[i]),
         .level         (level[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .long_press    (long_press[i]),
         .event_pulse   (event_pulse[i])
      );
   end : g_channel

endmodule : multi_button_conditioner
`default_nettype wire

// File: tb/tb_multi_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_button_conditioner
//  Purpose  : Directed self-checking bench, D=4 H=10 R=3, channel 3 active-low.
//             Inputs change 1 ns after a rising edge; outputs are sampled there.
//             A raw change driven in cycle c is sampled at edge c+1 and its
//             pulse is visible 7 steps after the drive.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_button_conditioner;

   logic       clk;
   logic       reset;
   logic [3:0] raw_buttons;
   logic [3:0] level;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic [3:0] long_press;
   logic [3:0] event_pulse;

   int total;
   int bad;

   multi_button_conditioner #(
      .NUM_CHANNELS    (4),
      .ACTIVE_LOW      (4'b1000),
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (10),
      .REPEAT_CYCLES   (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .raw_buttons   (raw_buttons),
      .level         (level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_press    (long_press),
      .event_pulse   (event_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [3:0] any_out;
      reset       = 1'b1;
      raw_buttons = 4'b1000;
      step(3);
      total++;
      if ({level, press_pulse, release_pulse, long_press, event_pulse} !== 20'h0) begin
         bad++;
         $display("FAIL reset_outputs got %h want 00000",
                  {level, press_pulse, release_pulse, long_press, event_pulse});
      end
      reset   = 1'b0;
      any_out = 4'b0;
      for (int j = 0; j < 10; j++) begin
         step(1);
         any_out = any_out | level | press_pulse | release_pulse | event_pulse;
      end
      total++;
      if (any_out !== 4'b0000) begin
         bad++;
         $display("FAIL idle_after_reset got %b want 0000", any_out);
      end
   endtask

   task automatic test_clean_press();
      raw_buttons[0] = 1'b1;
      step(6);
      total++;
      if ({level[0], press_pulse[0]} !== 2'b00) begin
         bad++;
         $display("FAIL press0_early got %b want 00", {level[0], press_pulse[0]});
      end
      step(1);
      total++;
      if ({level[0], press_pulse[0], event_pulse[0]} !== 3'b111) begin
         bad++;
         $display("FAIL press0_edge got %b want 111", {level[0], press_pulse[0], event_pulse[0]});
      end
      step(1);
      total++;
      if ({level[0], press_pulse[0], event_pulse[0]} !== 3'b100) begin
         bad++;
         $display("FAIL press0_width got %b want 100", {level[0], press_pulse[0], event_pulse[0]});
      end
      raw_buttons[0] = 1'b0;
      step(6);
      total++;
      if ({level[0], release_pulse[0]} !== 2'b10) begin
         bad++;
         $display("FAIL release0_early got %b want 10", {level[0], release_pulse[0]});
      end
      step(1);
      total++;
      if ({level[0], release_pulse[0], event_pulse[0]} !== 3'b010) begin
         bad++;
         $display("FAIL release0_edge got %b want 010", {level[0], release_pulse[0], event_pulse[0]});
      end
      step(1);
      total++;
      if (release_pulse[0] !== 1'b0) begin
         bad++;
         $display("FAIL release0_width got %b want 0", release_pulse[0]);
      end
      step(5);
   endtask

   task automatic test_bounce();
      logic vals[4];
      int   wid[4];
      int   n_press;
      int   first_at;
      logic seen_level;
      vals     = '{1'b1, 1'b0, 1'b1, 1'b0};
      wid      = '{2, 1, 3, 2};
      n_press  = 0;
      first_at = -1;
      for (int s = 0; s < 4; s++) begin
         raw_buttons[1] = vals[s];
         for (int j = 0; j < wid[s]; j++) begin
            step(1);
            n_press += int'(press_pulse[1]);
         end
      end
      raw_buttons[1] = 1'b1;
      for (int j = 1; j <= 14; j++) begin
         step(1);
         if (press_pulse[1] && first_at < 0) first_at = j;
         n_press += int'(press_pulse[1]);
      end
      total++;
      if (n_press !== 1) begin
         bad++;
         $display("FAIL bounce_press_count got %0d want 1", n_press);
      end
      total++;
      if (first_at !== 7) begin
         bad++;
         $display("FAIL bounce_press_time got %0d want 7", first_at);
      end
      raw_buttons[1] = 1'b0;
      step(10);
      total++;
      if (level[1] !== 1'b0) begin
         bad++;
         $display("FAIL bounce_release got %b want 0", level[1]);
      end
      raw_buttons[1] = 1'b1;
      step(3);
      raw_buttons[1] = 1'b0;
      seen_level     = 1'b0;
      for (int j = 0; j < 10; j++) begin
         step(1);
         seen_level = seen_level | level[1] | press_pulse[1];
      end
      total++;
      if (seen_level !== 1'b0) begin
         bad++;
         $display("FAIL glitch3_ignored got %b want 0", seen_level);
      end
   endtask

   task automatic test_hold();
      logic [2:0] exp_v;
      raw_buttons[2] = 1'b1;
      step(7);
      total++;
      if ({press_pulse[2], event_pulse[2], long_press[2]} !== 3'b110) begin
         bad++;
         $display("FAIL hold_press got %b want 110", {press_pulse[2], event_pulse[2], long_press[2]});
      end
      for (int j = 1; j <= 35; j++) begin
         step(1);
         exp_v[2] = (j == 10);
         exp_v[1] = (j >= 10) && (j < 31) && (((j - 10) % 3) == 0);
         exp_v[0] = (j == 31);
         total++;
         if ({long_press[2], event_pulse[2], release_pulse[2]} !== exp_v) begin
            bad++;
            $display("FAIL hold_cycle_P+%0d got %b want %b", j,
                     {long_press[2], event_pulse[2], release_pulse[2]}, exp_v);
         end
         if (j == 24) raw_buttons[2] = 1'b0;
      end
      total++;
      if (level[2] !== 1'b0) begin
         bad++;
         $display("FAIL hold_level_after got %b want 0", level[2]);
      end
   endtask

   task automatic test_active_low();
      raw_buttons[3] = 1'b0;
      step(6);
      total++;
      if (level[3] !== 1'b0) begin
         bad++;
         $display("FAIL al3_early got %b want 0", level[3]);
      end
      step(1);
      total++;
      if ({level[3], press_pulse[3]} !== 2'b11) begin
         bad++;
         $display("FAIL al3_press got %b want 11", {level[3], press_pulse[3]});
      end
      raw_buttons[3] = 1'b1;
      step(7);
      total++;
      if ({level[3], release_pulse[3]} !== 2'b01) begin
         bad++;
         $display("FAIL al3_release got %b want 01", {level[3], release_pulse[3]});
      end
      step(5);
   endtask

   task automatic test_simultaneous();
      logic [3:0] exp_v;
      raw_buttons[0] = 1'b1;
      raw_buttons[2] = 1'b1;
      step(7);
      total++;
      if ({press_pulse, event_pulse} !== 8'b0101_0101) begin
         bad++;
         $display("FAIL simul_press got %b want 01010101", {press_pulse, event_pulse});
      end
      for (int j = 1; j <= 15; j++) begin
         step(1);
         exp_v[3] = (j == 10) || (j == 13);
         exp_v[2] = (j == 10);
         exp_v[1] = (j == 13);
         exp_v[0] = 1'b0;
         total++;
         if ({event_pulse[0], event_pulse[2], release_pulse[2], release_pulse[0]} !== exp_v) begin
            bad++;
            $display("FAIL simul_cycle_P+%0d got %b want %b", j,
                     {event_pulse[0], event_pulse[2], release_pulse[2], release_pulse[0]}, exp_v);
         end
         if (j == 6) raw_buttons[2] = 1'b0;
      end
      raw_buttons[0] = 1'b0;
      step(10);
   endtask

   task automatic test_reset_mid_repeat();
      raw_buttons[1] = 1'b1;
      step(7);
      total++;
      if (press_pulse[1] !== 1'b1) begin
         bad++;
         $display("FAIL rst_pre_press got %b want 1", press_pulse[1]);
      end
      step(14);
      reset = 1'b1;
      step(1);
      total++;
      if ({level, press_pulse, release_pulse, long_press, event_pulse} !== 20'h0) begin
         bad++;
         $display("FAIL rst_mid_outputs got %h want 00000",
                  {level, press_pulse, release_pulse, long_press, event_pulse});
      end
      step(1);
      reset = 1'b0;
      step(6);
      total++;
      if ({level, press_pulse, release_pulse} !== 12'h0) begin
         bad++;
         $display("FAIL rst_post_early got %h want 000", {level, press_pulse, release_pulse});
      end
      step(1);
      total++;
      if ({level, press_pulse, release_pulse} !== 12'h220) begin
         bad++;
         $display("FAIL rst_post_press got %h want 220", {level, press_pulse, release_pulse});
      end
      raw_buttons[1] = 1'b0;
      step(10);
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      reset       = 1'b1;
      raw_buttons = 4'b1000;
      test_reset();
      test_clean_press();
      test_bounce();
      test_hold();
      test_active_low();
      test_simultaneous();
      test_reset_mid_repeat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_multi_button_conditioner
`default_nettype wire
